// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches one instruction per
// request/ready handshake and issues it to decode with a valid/stall handshake.
module pc_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              CLRN,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] JUMP_TARGET,
  output logic              IM_REQ,
  output logic [ADDR_W-1:0] IM_ADDR,
  input  logic              IM_READY,
  input  logic [31:0]       IM_DATA,
  output logic [31:0]       INST,
  output logic              INST_VALID,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_PLUS4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] next_pc;

  assign pc_plus4 = pc_q + FOUR;

  // Jump outranks branch; both targets are word-aligned before use.
  always_comb begin
    next_pc = pc_plus4;
    if (JUMP) begin
      next_pc = JUMP_TARGET & ALIGN_MASK;
    end else if (BRANCH_TAKEN) begin
      next_pc = BRANCH_TARGET & ALIGN_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (IM_READY) begin
          inst_d  = IM_DATA;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!STALL) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  assign IM_REQ     = (state_q == FETCH);
  assign INST_VALID = (state_q == ISSUE);
  assign IM_ADDR    = pc_q;
  assign PC         = pc_q;
  assign PC_PLUS4   = pc_plus4;
  assign INST       = inst_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: transaction-level model of fetch/issue
// with randomized wait states, stalls, redirects and ignored-input noise.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        CLK;
  logic        CLRN;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [31:0] JUMP_TARGET;
  logic        IM_REQ;
  logic [31:0] IM_ADDR;
  logic        IM_READY;
  logic [31:0] IM_DATA;
  logic [31:0] INST;
  logic        INST_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;

  pc_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (RPC)
  ) dut (
    .CLK           (CLK),
    .CLRN          (CLRN),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP          (JUMP),
    .JUMP_TARGET   (JUMP_TARGET),
    .IM_REQ        (IM_REQ),
    .IM_ADDR       (IM_ADDR),
    .IM_READY      (IM_READY),
    .IM_DATA       (IM_DATA),
    .INST          (INST),
    .INST_VALID    (INST_VALID),
    .PC            (PC),
    .PC_PLUS4      (PC_PLUS4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_redirect();
    JUMP          = 1'($urandom_range(0, 1));
    BRANCH_TAKEN  = 1'($urandom_range(0, 1));
    JUMP_TARGET   = $urandom;
    BRANCH_TARGET = $urandom;
  endtask

  // Entered with CLRN already low; ends at a negedge in the first FETCH cycle.
  task automatic do_reset();
    exp_pc   = RPC;
    exp_inst = '0;
    @(negedge CLK);
    chk("rst_im_req", {31'b0, IM_REQ}, 32'd0);
    chk("rst_valid",  {31'b0, INST_VALID}, 32'd0);
    chk("rst_inst",   INST, 32'd0);
    chk("rst_pc",     PC, RPC);
    chk("rst_plus4",  PC_PLUS4, RPC + 32'd4);
    chk("rst_addr",   IM_ADDR, RPC);
    CLRN = 1'b1;
    #1;
    chk("idle_im_req", {31'b0, IM_REQ}, 32'd0);
    @(negedge CLK);
  endtask

  // Entered at a negedge of a FETCH cycle; ends at the first ISSUE negedge.
  task automatic do_fetch(input int unsigned waits, input logic [31:0] data);
    for (int unsigned i = 0; i <= waits; i++) begin
      chk("fetch_req",   {31'b0, IM_REQ}, 32'd1);
      chk("fetch_addr",  IM_ADDR, exp_pc);
      chk("fetch_valid", {31'b0, INST_VALID}, 32'd0);
      junk_redirect();
      STALL    = 1'($urandom_range(0, 1));
      IM_READY = (i == waits);
      IM_DATA  = (i == waits) ? data : $urandom;
      @(negedge CLK);
    end
    exp_inst = data;
  endtask

  // Entered at an ISSUE negedge; ends at the next FETCH negedge.
  task automatic do_issue(input int unsigned stalls, input logic force_redir,
                          input logic j, input logic [31:0] jt,
                          input logic b, input logic [31:0] bt);
    for (int unsigned i = 0; i <= stalls; i++) begin
      chk("issue_valid", {31'b0, INST_VALID}, 32'd1);
      chk("issue_req",   {31'b0, IM_REQ}, 32'd0);
      chk("issue_inst",  INST, exp_inst);
      chk("issue_pc",    PC, exp_pc);
      chk("issue_plus4", PC_PLUS4, exp_pc + 32'd4);
      IM_READY = 1'($urandom_range(0, 1));
      IM_DATA  = $urandom;
      if (i < stalls) begin
        STALL = 1'b1;
        junk_redirect();
        if (force_redir) begin
          JUMP        = 1'b1;
          JUMP_TARGET = 32'hDEAD_BEE0;
        end
      end else begin
        STALL         = 1'b0;
        JUMP          = j;
        JUMP_TARGET   = jt;
        BRANCH_TAKEN  = b;
        BRANCH_TARGET = bt;
      end
      @(negedge CLK);
    end
    if (j)      exp_pc = {jt[31:2], 2'b00};
    else if (b) exp_pc = {bt[31:2], 2'b00};
    else        exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    CLRN = 1'b0; STALL = 1'b0; JUMP = 1'b0; BRANCH_TAKEN = 1'b0;
    JUMP_TARGET = '0; BRANCH_TARGET = '0; IM_READY = 1'b0; IM_DATA = '0;
    do_reset();

    // First fetch, zero-wait memory.
    chk("first_req",  {31'b0, IM_REQ}, 32'd1);
    chk("first_addr", IM_ADDR, 32'h0000_0100);
    do_fetch(0, 32'h2002_0005);
    chk("first_inst", INST, 32'h2002_0005);
    chk("first_pc",   PC, 32'h0000_0100);
    do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Sequential fetch with three wait cycles each.
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr", IM_ADDR, 32'h104 + 32'(4 * k));
      do_fetch(3, $urandom);
      do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);
    end

    // Five-cycle stall, then plain consume.
    do_fetch(1, $urandom);
    do_issue(5, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("post_stall_addr", IM_ADDR, 32'h0000_0114);

    // Jump beats branch and is word-aligned.
    do_fetch(0, $urandom);
    do_issue(0, 1'b0, 1'b1, 32'h0000_2003, 1'b1, 32'h0000_0300);
    chk("jump_addr", IM_ADDR, 32'h0000_2000);

    // Branch alone, misaligned target.
    do_fetch(2, $urandom);
    do_issue(1, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0307);
    chk("branch_addr", IM_ADDR, 32'h0000_0304);

    // Redirect shown only during stall is dropped.
    do_fetch(0, $urandom);
    do_issue(3, 1'b1, 1'b0, '0, 1'b0, '0);
    chk("stall_redir_addr", IM_ADDR, 32'h0000_0308);

    // Wrap-around at the top of the address space.
    do_fetch(0, $urandom);
    do_issue(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, '0);
    do_fetch(0, $urandom);
    chk("wrap_pc",    PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0000_0000);
    do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("wrap_addr", IM_ADDR, 32'h0000_0000);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      logic        rj, rb;
      logic [31:0] rjt, rbt;
      rj  = ($urandom_range(0, 3) == 0);
      rb  = ($urandom_range(0, 2) == 0);
      rjt = $urandom;
      rbt = $urandom;
      do_fetch($urandom_range(0, 3), $urandom);
      do_issue($urandom_range(0, 3), 1'b0, rj, rjt, rb, rbt);
    end

    // Asynchronous reset in the middle of a fetch.
    do_fetch(0, $urandom);
    do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);
    chk("pre_areset_req", {31'b0, IM_REQ}, 32'd1);
    #2 CLRN = 1'b0;
    #1;
    chk("areset_req",   {31'b0, IM_REQ}, 32'd0);
    chk("areset_valid", {31'b0, INST_VALID}, 32'd0);
    chk("areset_pc",    PC, RPC);
    chk("areset_inst",  INST, 32'd0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("reseq_addr", IM_ADDR, RPC + 32'(4 * k));
      do_fetch(3, $urandom);
      do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);
    end

    // Asynchronous reset during issue.
    do_fetch(0, 32'h1234_5678);
    #2 CLRN = 1'b0;
    #1;
    chk("ireset_valid", {31'b0, INST_VALID}, 32'd0);
    chk("ireset_inst",  INST, 32'd0);
    chk("ireset_pc",    PC, RPC);
    do_reset();
    do_fetch(0, 32'hCAFE_F00D);
    do_issue(0, 1'b0, 1'b0, '0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
